// File: rtl/axi_lite_pkg.sv
// Shared types, response codes and FSM state encoding for the AXI4-Lite responder.
// The window helper is only referenced when AXI_LITE_SLV_DECERR_EN is defined.
package axi_lite_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;
    typedef logic [1:0]        resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        BRESP,
        RRESP
    } state_e;

    // 33-bit compare so a window ending exactly at 2^32 is representable.
    function automatic logic addr_in_window(input addr_t addr, input addr_t base, input addr_t size);
        logic [ADDR_W:0] a;
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/axi_lite_slv_wcollect.sv
// Write-side collector: captures AW and W independently, in either order, and
// holds them until the B handshake clears the pair.
module axi_lite_slv_wcollect
    import axi_lite_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  accept_en,
    input  logic  clear,
    input  addr_t awaddr,
    input  logic  awvalid,
    output logic  awready,
    input  data_t wdata,
    input  strb_t wstrb,
    input  logic  wvalid,
    output logic  wready,
    output logic  aw_hold,
    output logic  w_hold,
    output logic  wr_complete,
    output addr_t wr_addr,
    output data_t wr_data,
    output strb_t wr_strb
);

    logic  aw_hold_q, aw_hold_d;
    logic  w_hold_q, w_hold_d;
    addr_t addr_q, addr_d;
    data_t data_q, data_d;
    strb_t strb_q, strb_d;
    logic  aw_hs, w_hs;

    always_comb begin
        awready  = accept_en & ~aw_hold_q;
        wready   = accept_en & ~w_hold_q;
        aw_hs    = awvalid & awready;
        w_hs     = wvalid & wready;
        addr_d   = aw_hs ? awaddr : addr_q;
        data_d   = w_hs ? wdata : data_q;
        strb_d   = w_hs ? wstrb : strb_q;
        aw_hold_d = clear ? 1'b0 : (aw_hold_q | aw_hs);
        w_hold_d  = clear ? 1'b0 : (w_hold_q | w_hs);
    end

    // Look-ahead outputs let the FSM leave IDLE in the same cycle the pair completes.
    assign wr_complete = aw_hold_d & w_hold_d;
    assign wr_addr     = addr_d;
    assign wr_data     = data_d;
    assign wr_strb     = strb_d;
    assign aw_hold     = aw_hold_q;
    assign w_hold      = w_hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_hold_q <= 1'b0;
            w_hold_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            aw_hold_q <= aw_hold_d;
            w_hold_q  <= w_hold_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

endmodule

// File: rtl/axi_lite_slave_ctrl.sv
// AXI4-Lite responder serialising AW/W/B and AR/R into one request/response port.
// Define AXI_LITE_SLV_DECERR_EN to answer out-of-window addresses locally with DECERR.
module axi_lite_slave_ctrl
    import axi_lite_pkg::*;
#(
    parameter addr_t ADDR_BASE = 32'h0000_0000,
    parameter addr_t ADDR_SIZE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  addr_t       s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  data_t       s_axi_wdata,
    input  strb_t       s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output resp_t       s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  addr_t       s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output data_t       s_axi_rdata,
    output resp_t       s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output addr_t       req_addr,
    output data_t       req_wdata,
    output strb_t       req_strb,
    input  logic        rsp_valid,
    input  data_t       rsp_rdata,
    input  logic        rsp_err
);

    state_e state_q, state_d;
    logic   prio_wr_q, prio_wr_d;
    logic   req_write_q, req_write_d;
    addr_t  req_addr_q, req_addr_d;
    data_t  req_wdata_q, req_wdata_d;
    strb_t  req_strb_q, req_strb_d;
    data_t  rdata_q, rdata_d;
    resp_t  resp_q, resp_d;

    logic   rd_grant, wr_clear, accept_en;
    logic   aw_hold, w_hold, wr_complete;
    addr_t  wr_addr;
    data_t  wr_data;
    strb_t  wr_strb;
    logic   rd_addr_ok, wr_addr_ok;
    logic   unused_sig;

`ifdef AXI_LITE_SLV_DECERR_EN
    assign rd_addr_ok = addr_in_window(s_axi_araddr, ADDR_BASE, ADDR_SIZE);
    assign wr_addr_ok = addr_in_window(wr_addr, ADDR_BASE, ADDR_SIZE);
    assign unused_sig = ^{s_axi_awprot, s_axi_arprot};
`else
    assign rd_addr_ok = 1'b1;
    assign wr_addr_ok = 1'b1;
    assign unused_sig = ^{s_axi_awprot, s_axi_arprot, ADDR_BASE, ADDR_SIZE, RESP_DECERR};
`endif

    // A half-captured write always blocks reads; otherwise prio_wr breaks ties.
    assign rd_grant  = (state_q == IDLE) & ~rst & s_axi_arvalid & ~aw_hold & ~w_hold &
                       (~(s_axi_awvalid | s_axi_wvalid) | ~prio_wr_q);
    assign accept_en = (state_q == IDLE) & ~rst & ~rd_grant;
    assign s_axi_arready = rd_grant;

    axi_lite_slv_wcollect u_wcollect (
        .clk         (clk),
        .rst         (rst),
        .accept_en   (accept_en),
        .clear       (wr_clear),
        .awaddr      (s_axi_awaddr),
        .awvalid     (s_axi_awvalid),
        .awready     (s_axi_awready),
        .wdata       (s_axi_wdata),
        .wstrb       (s_axi_wstrb),
        .wvalid      (s_axi_wvalid),
        .wready      (s_axi_wready),
        .aw_hold     (aw_hold),
        .w_hold      (w_hold),
        .wr_complete (wr_complete),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb)
    );

    always_comb begin
        state_d     = state_q;
        prio_wr_d   = prio_wr_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_strb_d  = req_strb_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        wr_clear    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_grant) begin
                    req_write_d = 1'b0;
                    req_addr_d  = s_axi_araddr;
                    state_d     = ISSUE;
                    if (!rd_addr_ok) begin
                        resp_d  = RESP_DECERR;
                        rdata_d = '0;
                        state_d = RRESP;
                    end
                end else if (wr_complete) begin
                    req_write_d = 1'b1;
                    req_addr_d  = wr_addr;
                    req_wdata_d = wr_data;
                    req_strb_d  = wr_strb;
                    state_d     = ISSUE;
                    if (!wr_addr_ok) begin
                        resp_d  = RESP_DECERR;
                        state_d = BRESP;
                    end
                end
            end
            ISSUE: begin
                if (req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (rsp_valid) begin
                    resp_d = rsp_err ? RESP_SLVERR : RESP_OKAY;
                    if (req_write_q) begin
                        state_d = BRESP;
                    end else begin
                        rdata_d = rsp_rdata;
                        state_d = RRESP;
                    end
                end
            end
            BRESP: begin
                if (s_axi_bready) begin
                    wr_clear  = 1'b1;
                    prio_wr_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RRESP: begin
                if (s_axi_rready) begin
                    prio_wr_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_wr_q   <= 1'b1;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_strb_q  <= '0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            prio_wr_q   <= prio_wr_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_strb_q  <= req_strb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

    assign req_valid    = (state_q == ISSUE);
    assign req_write    = req_write_q;
    assign req_addr     = req_addr_q;
    assign req_wdata    = req_wdata_q;
    assign req_strb     = req_strb_q;
    assign s_axi_bvalid = (state_q == BRESP);
    assign s_axi_bresp  = s_axi_bvalid ? resp_q : RESP_OKAY;
    assign s_axi_rvalid = (state_q == RRESP);
    assign s_axi_rresp  = s_axi_rvalid ? resp_q : RESP_OKAY;
    assign s_axi_rdata  = rdata_q;

endmodule

// File: tb/tb_axi_lite_slave_ctrl.sv
// Scoreboard bench for axi_lite_slave_ctrl: stimulus pushes expected requests and
// responses, a monitor pops and compares whenever the DUT presents them.
module tb_axi_lite_slave_ctrl;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    addr_t       awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, arvalid, arready;
    data_t       wdata, rdata;
    strb_t       wstrb;
    resp_t       bresp, rresp;
    logic        bvalid, bready, rvalid, rready;
    logic        req_valid, req_ready, req_write;
    addr_t       req_addr;
    data_t       req_wdata;
    strb_t       req_strb;
    logic        rsp_valid, rsp_err;
    data_t       rsp_rdata;

    always #5 clk = ~clk;

    axi_lite_slave_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_strb      (req_strb),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err)
    );

    typedef struct { logic write; addr_t addr; data_t wdata; strb_t strb; } exp_req_t;
    typedef struct { logic write; resp_t resp; data_t rdata; } exp_rsp_t;
    typedef struct { data_t rdata; logic err; } apb_rsp_t;

    exp_req_t exp_req_q[$];
    exp_rsp_t exp_rsp_q[$];
    apb_rsp_t apb_q[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rsp_cyc = -10;
    logic rsp_hold = 1'b0;
    logic rsp_pending = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        tests++;
        fails++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_aw(input addr_t a);
        int   n;
        logic hs;
        n = 0;
        awaddr = a;
        awvalid = 1'b1;
        forever begin
            @(negedge clk);
            hs = awready;
            @(posedge clk);
            #1;
            if (hs) break;
            n++;
            if (n > 60) begin
                fail_now("aw_handshake_timeout", n, 60);
                break;
            end
        end
        awvalid = 1'b0;
    endtask

    task automatic drive_w(input data_t d, input strb_t s);
        int   n;
        logic hs;
        n = 0;
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        forever begin
            @(negedge clk);
            hs = wready;
            @(posedge clk);
            #1;
            if (hs) break;
            n++;
            if (n > 60) begin
                fail_now("w_handshake_timeout", n, 60);
                break;
            end
        end
        wvalid = 1'b0;
    endtask

    task automatic drive_ar(input addr_t a);
        int   n;
        logic hs;
        n = 0;
        araddr = a;
        arvalid = 1'b1;
        forever begin
            @(negedge clk);
            hs = arready;
            @(posedge clk);
            #1;
            if (hs) break;
            n++;
            if (n > 60) begin
                fail_now("ar_handshake_timeout", n, 60);
                break;
            end
        end
        arvalid = 1'b0;
    endtask

    task automatic wr(input addr_t a, input data_t d, input strb_t s);
        fork
            drive_aw(a);
            drive_w(d, s);
        join
    endtask

    task automatic push_req(input logic w, input addr_t a, input data_t d, input strb_t s);
        exp_req_t r;
        r.write = w; r.addr = a; r.wdata = d; r.strb = s;
        exp_req_q.push_back(r);
    endtask

    task automatic push_rsp(input logic w, input resp_t rc, input data_t d);
        exp_rsp_t e;
        e.write = w; e.resp = rc; e.rdata = d;
        exp_rsp_q.push_back(e);
    endtask

    task automatic push_apb(input data_t d, input logic err);
        apb_rsp_t p;
        p.rdata = d; p.err = err;
        apb_q.push_back(p);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_req_q.size() != 0 || exp_rsp_q.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            fail_now("drain_outstanding", exp_req_q.size() + exp_rsp_q.size(), 0);
            exp_req_q.delete();
            exp_rsp_q.delete();
            apb_q.delete();
        end
        idle(2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, awready, 0);
        check({tag, "_wready"}, wready, 0);
        check({tag, "_arready"}, arready, 0);
        check({tag, "_bvalid"}, bvalid, 0);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_req_valid"}, req_valid, 0);
        check({tag, "_bresp"}, bresp, 0);
        check({tag, "_rresp"}, rresp, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_req_write"}, req_write, 0);
        check({tag, "_req_addr"}, req_addr, 0);
        check({tag, "_req_wdata"}, req_wdata, 0);
        check({tag, "_req_strb"}, req_strb, 0);
    endtask

    // APB-side model: answers one cycle after each accepted request.
    initial begin
        apb_rsp_t p;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) rsp_pending = 1'b0;
            else if (req_valid && req_ready) rsp_pending = 1'b1;
            @(posedge clk);
            #1;
            rsp_valid = 1'b0;
            if (rst) begin
                rsp_pending = 1'b0;
            end else if (rsp_pending && !rsp_hold) begin
                rsp_pending = 1'b0;
                if (apb_q.size() == 0) begin
                    fail_now("apb_rsp_unplanned", 1, 0);
                end else begin
                    p = apb_q.pop_front();
                    rsp_rdata = p.rdata;
                    rsp_err   = p.err;
                    rsp_valid = 1'b1;
                end
            end
        end
    end

    // Monitor: compares every presented request/response against the queue heads.
    initial begin
        exp_req_t r;
        exp_rsp_t e;
        logic     bv_prev, rv_prev;
        bv_prev = 1'b0;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bv_prev = 1'b0;
                rv_prev = 1'b0;
                continue;
            end
            if (rsp_valid) rsp_cyc = cyc;
            if (req_valid) begin
                if (exp_req_q.size() == 0) begin
                    fail_now("req_unexpected", 1, 0);
                end else begin
                    r = exp_req_q[0];
                    check("req_write", req_write, r.write);
                    check("req_addr", req_addr, r.addr);
                    if (r.write) begin
                        check("req_wdata", req_wdata, r.wdata);
                        check("req_strb", req_strb, r.strb);
                    end
                    if (req_ready) begin
                        void'(exp_req_q.pop_front());
                        $display("[TB] req %s addr=0x%0h data=0x%0h strb=0x%0h",
                                 req_write ? "WR" : "RD", req_addr, req_wdata, req_strb);
                    end
                end
            end
            if (bvalid) begin
                if (exp_rsp_q.size() == 0) begin
                    fail_now("b_unexpected", 1, 0);
                end else begin
                    e = exp_rsp_q[0];
                    check("b_kind_is_write", e.write, 1);
                    check("bresp", bresp, e.resp);
                    if (!bv_prev && e.resp != RESP_DECERR) check("b_latency", cyc, rsp_cyc + 1);
                    if (bready) begin
                        void'(exp_rsp_q.pop_front());
                        $display("[TB] B bresp=%b", bresp);
                    end
                end
            end
            if (rvalid) begin
                if (exp_rsp_q.size() == 0) begin
                    fail_now("r_unexpected", 1, 0);
                end else begin
                    e = exp_rsp_q[0];
                    check("r_kind_is_read", e.write, 0);
                    check("rresp", rresp, e.resp);
                    check("rdata", rdata, e.rdata);
                    if (!rv_prev && e.resp != RESP_DECERR) check("r_latency", cyc, rsp_cyc + 1);
                    if (rready) begin
                        void'(exp_rsp_q.pop_front());
                        $display("[TB] R rresp=%b rdata=0x%0h", rresp, rdata);
                    end
                end
            end
            bv_prev = bvalid && !bready;
            rv_prev = rvalid && !rready;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        logic done;
        rst = 1'b1;
        awprot = 3'b000; arprot = 3'b000;
        awaddr = 32'h4; araddr = 32'h4; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b1; rready = 1'b1; req_ready = 1'b1;

        // Reset state with every valid asserted.
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rst = 1'b0;
        idle(2);

        // Contention: write wins after reset, then read wins over a fresh write.
        push_req(1, 32'h8, 32'hA5A5_0008, 4'hF); push_apb(32'h0, 0);             push_rsp(1, RESP_OKAY, 32'h0);
        push_req(0, 32'h4, 32'h0, 4'h0);         push_apb(32'hCAFE_0004, 0);     push_rsp(0, RESP_OKAY, 32'hCAFE_0004);
        push_req(1, 32'hC, 32'h0000_000C, 4'h3); push_apb(32'h0, 1);             push_rsp(1, RESP_SLVERR, 32'h0);
        fork
            begin
                wr(32'h8, 32'hA5A5_0008, 4'hF);
                wr(32'hC, 32'h0000_000C, 4'h3);
            end
            drive_ar(32'h4);
        join
        drain();

        // Single write, W two cycles after AW.
        push_req(1, 32'h10, 32'hDEAD_BEEF, 4'hF); push_apb(32'h0, 0); push_rsp(1, RESP_OKAY, 32'h0);
        fork
            drive_aw(32'h10);
            begin
                idle(2);
                drive_w(32'hDEAD_BEEF, 4'hF);
            end
        join
        drain();

        // Single read with SLVERR and rready held off for 3 cycles.
        rready = 1'b0;
        push_req(0, 32'h20, 32'h0, 4'h0); push_apb(32'h1234_5678, 1); push_rsp(0, RESP_SLVERR, 32'h1234_5678);
        drive_ar(32'h20);
        n = 0;
        while (!rvalid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) fail_now("rvalid_timeout", n, 20);
        idle(3);
        rready = 1'b1;
        drain();

        // W first, AR pending, AW later: AR must stay blocked until B completes.
        push_req(1, 32'h34, 32'h1122_3344, 4'hF); push_apb(32'h0, 0);         push_rsp(1, RESP_OKAY, 32'h0);
        push_req(0, 32'h30, 32'h0, 4'h0);         push_apb(32'h5566_7788, 0); push_rsp(0, RESP_OKAY, 32'h5566_7788);
        wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        check("w_first_wready", wready, 1);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        araddr = 32'h30; arvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ar_blocked_by_w_hold", arready, 0);
            @(posedge clk);
            #1;
        end
        awaddr = 32'h34; awvalid = 1'b1;
        @(negedge clk);
        check("aw_late_awready", awready, 1);
        check("ar_blocked_at_aw", arready, 0);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            check("ar_blocked_until_b", arready, 0);
            done = bvalid && bready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) fail_now("b_wait_timeout", n, 20);
        @(negedge clk);
        check("ar_granted_after_b", arready, 1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        drain();

        // Request backpressure: payload must hold while req_ready is low.
        req_ready = 1'b0;
        push_req(1, 32'h40, 32'h0BAD_F00D, 4'h5); push_apb(32'h0, 0); push_rsp(1, RESP_OKAY, 32'h0);
        wr(32'h40, 32'h0BAD_F00D, 4'h5);
        repeat (5) begin
            @(negedge clk);
            check("req_valid_stalled", req_valid, 1);
            @(posedge clk);
            #1;
        end
        req_ready = 1'b1;
        drain();

        // Reset while waiting for the APB response: no B may follow.
        rsp_hold = 1'b1;
        push_req(1, 32'h50, 32'h0000_0050, 4'hF);
        wr(32'h50, 32'h0000_0050, 4'hF);
        idle(1);
        #2;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        check("midreset_req_consumed", exp_req_q.size(), 0);
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rst = 1'b0;
        rsp_hold = 1'b0;
        idle(1);
        push_req(1, 32'h60, 32'h600D_600D, 4'hF); push_apb(32'h0, 0); push_rsp(1, RESP_OKAY, 32'h0);
        wr(32'h60, 32'h600D_600D, 4'hF);
        drain();

`ifdef AXI_LITE_SLV_DECERR_EN
        // Outside the window: local DECERR, no request; last in-window word forwarded.
        push_rsp(0, RESP_DECERR, 32'h0);
        drive_ar(32'h1000);
        drain();
        push_req(1, 32'hFFC, 32'h0000_0FFC, 4'hF); push_apb(32'h0, 0); push_rsp(1, RESP_OKAY, 32'h0);
        wr(32'hFFC, 32'h0000_0FFC, 4'hF);
        drain();
`endif

        check("apb_queue_empty", apb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
